// File: rtl/cond_pkg.sv
// Shared types for the condition/flag unit: ARM condition codes, branch
// modes and the packed {N,Z,C,V} flag word.
package cond_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef enum logic [MODE_W-1:0] {
    BR_BCOND = 2'b00,
    BR_CBZ   = 2'b01,
    BR_CBNZ  = 2'b10,
    BR_B     = 2'b11
  } br_mode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Stateless ARM condition-code evaluator.
// Ports:
//   flags       - {N,Z,C,V} to test against
//   cond        - condition code
//   cond_true_c - 1 when the condition holds (combinational)
module cond_eval
  import cond_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   cond_true_c
);

  // Condition table; AL and NV both evaluate true.
  always_comb begin
    cond_true_c = 1'b0;
    unique case (cond)
      EQ: cond_true_c = flags.z;
      NE: cond_true_c = !flags.z;
      CS: cond_true_c = flags.c;
      CC: cond_true_c = !flags.c;
      MI: cond_true_c = flags.n;
      PL: cond_true_c = !flags.n;
      VS: cond_true_c = flags.v;
      VC: cond_true_c = !flags.v;
      HI: cond_true_c = flags.c && !flags.z;
      LS: cond_true_c = !flags.c || flags.z;
      GE: cond_true_c = (flags.n == flags.v);
      LT: cond_true_c = (flags.n != flags.v);
      GT: cond_true_c = !flags.z && (flags.n == flags.v);
      LE: cond_true_c = flags.z || (flags.n != flags.v);
      AL: cond_true_c = 1'b1;
      NV: cond_true_c = 1'b1;
      default: cond_true_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Condition flag register plus branch-decision unit with a saturating
// taken-branch counter.
// Optional macro COND_FLAG_BYPASS_EN: a BCOND request in the same cycle as
// flag_we sees the incoming flags; otherwise it sees the stored flags.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   flag_we, *_in              - latch new ALU flags {N,Z,C,V}
//   eval_valid, cond, br_mode  - branch evaluation request
//   op_zero                    - CBZ/CBNZ operand is zero
//   take_valid, take_branch    - registered decision, one cycle latency
//   flags_q                    - stored flags {N,Z,C,V}
//   taken_count                - saturating count of taken branches
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flag_we,
  input  logic               negative_in,
  input  logic               zero_in,
  input  logic               carry_in,
  input  logic               overflow_in,
  input  logic               eval_valid,
  input  logic [COND_W-1:0]  cond,
  input  logic [MODE_W-1:0]  br_mode,
  input  logic               op_zero,
  output logic               take_valid,
  output logic               take_branch,
  output logic [FLAGS_W-1:0] flags_q,
  output logic [CNT_W-1:0]   taken_count
);

  flags_t flags_r;
  flags_t flags_in_c;
  flags_t eval_flags_c;
  logic   cond_true_c;
  logic   decision_c;

  assign flags_in_c = flags_t'({negative_in, zero_in, carry_in, overflow_in});
  assign flags_q    = FLAGS_W'(flags_r);

  // Flags seen by the condition evaluator.
`ifdef COND_FLAG_BYPASS_EN
  assign eval_flags_c = flag_we ? flags_in_c : flags_r;
`else
  assign eval_flags_c = flags_r;
`endif

  cond_eval u_cond_eval (
    .flags       (eval_flags_c),
    .cond        (cond_e'(cond)),
    .cond_true_c (cond_true_c)
  );

  // Branch decision by mode; flags only matter for BCOND.
  always_comb begin
    decision_c = 1'b0;
    unique case (br_mode_e'(br_mode))
      BR_BCOND: decision_c = cond_true_c;
      BR_CBZ:   decision_c = op_zero;
      BR_CBNZ:  decision_c = !op_zero;
      BR_B:     decision_c = 1'b1;
      default:  decision_c = 1'b0;
    endcase
  end

  // State: flags, decision pipeline stage and taken counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r     <= '0;
      take_valid  <= 1'b0;
      take_branch <= 1'b0;
      taken_count <= '0;
    end else begin
      if (flag_we) begin
        flags_r <= flags_in_c;
      end
      take_valid <= eval_valid;
      if (eval_valid) begin
        take_branch <= decision_c;
        // Counter advances on the same edge the taken decision is registered.
        if (decision_c && (taken_count != {CNT_W{1'b1}})) begin
          taken_count <= taken_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             flag_we;
  logic             negative_in, zero_in, carry_in, overflow_in;
  logic             eval_valid;
  logic [3:0]       cond;
  logic [1:0]       br_mode;
  logic             op_zero;
  logic             take_valid;
  logic             take_branch;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] taken_count;

  typedef struct packed {
    logic             tb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  localparam logic [1:0] M_BCOND = 2'b00;
  localparam logic [1:0] M_CBZ   = 2'b01;
  localparam logic [1:0] M_CBNZ  = 2'b10;
  localparam logic [1:0] M_B     = 2'b11;

  always #5 clk = ~clk;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flag_we     (flag_we),
    .negative_in (negative_in),
    .zero_in     (zero_in),
    .carry_in    (carry_in),
    .overflow_in (overflow_in),
    .eval_valid  (eval_valid),
    .cond        (cond),
    .br_mode     (br_mode),
    .op_zero     (op_zero),
    .take_valid  (take_valid),
    .take_branch (take_branch),
    .flags_q     (flags_q),
    .taken_count (taken_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented decision is matched against the scoreboard.
  always @(negedge clk) begin
    if (take_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_take_valid", 32'(take_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("take_branch", 32'(take_branch), 32'(e.tb));
        check("taken_count", 32'(taken_count), 32'(e.cnt));
      end
    end
  end

  // Drive one cycle of stimulus; push the hand-computed decision when a request is live.
  task automatic cyc(input logic we, input logic [3:0] f, input logic ev,
                     input logic [3:0] c, input logic [1:0] m, input logic oz,
                     input logic exp_tb);
    flag_we = we;
    {negative_in, zero_in, carry_in, overflow_in} = f;
    eval_valid = ev;
    cond = c;
    br_mode = m;
    op_zero = oz;
    if (ev && !reset) begin
      if (exp_tb && model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + CNT_W'(1);
      sb_q.push_back('{tb: exp_tb, cnt: model_cnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, M_BCOND, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic with_req);
    reset = 1'b1;
    cyc(1'b0, 4'b0000, with_req, 4'b1110, M_B, 1'b0, 1'b1);
    reset = 1'b0;
    model_cnt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_same;
    reset = 1'b0;
    idle();
    do_reset(1'b0);
    check("rst_flags_q", 32'(flags_q), 32'h0);
    check("rst_take_valid", 32'(take_valid), 32'h0);
    check("rst_take_branch", 32'(take_branch), 32'h0);
    check("rst_taken_count", 32'(taken_count), 32'h0);

    // Flags 0000 after reset: EQ not taken, NE taken (back-to-back).
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0001, M_BCOND, 1'b0, 1'b1);
    idle();
    check("hold_take_valid", 32'(take_valid), 32'h0);
    check("hold_take_branch", 32'(take_branch), 32'h1);

    // N=1,V=0: GE 0, LT 1, GT 0, LE 1.
    cyc(1'b1, 4'b1000, 1'b0, 4'b0000, M_BCOND, 1'b0, 1'b0);
    check("flags_nv", 32'(flags_q), 32'h8);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1010, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1011, M_BCOND, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1100, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1101, M_BCOND, 1'b0, 1'b1);

    // Z=1,C=1: HI 0, LS 1; MI 0, CS 1.
    cyc(1'b1, 4'b0110, 1'b0, 4'b0000, M_BCOND, 1'b0, 1'b0);
    check("flags_zc", 32'(flags_q), 32'h6);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1000, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1001, M_BCOND, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0100, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0010, M_BCOND, 1'b0, 1'b1);

    // Same-cycle flag write Z=1 with EQ over stored Z=0.
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, M_BCOND, 1'b0, 1'b0);
`ifdef COND_FLAG_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    cyc(1'b1, 4'b0100, 1'b1, 4'b0000, M_BCOND, 1'b0, exp_same);
    check("flags_same_cycle", 32'(flags_q), 32'h4);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_BCOND, 1'b0, 1'b1);

    // CBZ/CBNZ/B ignore flags; flags_q stays 0000.
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, M_BCOND, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_CBZ,  1'b1, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_CBNZ, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_CBZ,  1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_CBNZ, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_B,    1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1111, M_BCOND, 1'b0, 1'b1);
    idle();
    check("flags_unchanged", 32'(flags_q), 32'h0);

    // Saturation: 9 taken B requests give counts 1..7 then 7, 7.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_B, 1'b0, 1'b1);
    check("sat_count", 32'(taken_count), 32'h7);

    // Reset mid-stream with a live request: request dropped, counter cleared.
    do_reset(1'b1);
    check("midrst_take_valid", 32'(take_valid), 32'h0);
    check("midrst_taken_count", 32'(taken_count), 32'h0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, M_B, 1'b0, 1'b1);
    idle();
    idle();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter: CNT_W, default 16, width of taken-branch counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flag_we  input  1  latch new ALU flags this cycle (flag-setting op).
REQ-005 SHALL have port: negative_in, zero_in, carry_in, overflow_in  input  1 each  ALU flags; zero_in comes from the ALU's 64-bit zero detector.
REQ-006 SHALL have port: eval_valid  input  1  branch evaluation request.
REQ-007 SHALL have port: cond  input  4  ARM condition code, used when br_mode = BCOND.
REQ-008 SHALL have port: br_mode  input  2  00 BCOND, 01 CBZ, 10 CBNZ, 11 B (unconditional).
REQ-009 SHALL have port: op_zero  input  1  zero-detect of the CBZ/CBNZ register operand.
REQ-010 SHALL have port: take_valid  output  1  registered; high one cycle after eval_valid.
REQ-011 SHALL have port: take_branch  output  1  registered branch decision; qualified by take_valid.
REQ-012 SHALL have port: flags_q  output  4  stored {N,Z,C,V}.
REQ-013 SHALL have port: taken_count  output  CNT_W  saturating count of taken branches.

Function
REQ-014 SHALL load flags_q <= {negative_in,zero_in,carry_in,overflow_in} on clk when flag_we=1; otherwise hold.
REQ-015 SHALL register take_valid <= eval_valid each cycle; latency exactly 1 cycle, no stall, back-to-back requests every cycle.
REQ-016 SHALL compute take_branch: BCOND -> cond table; CBZ -> op_zero; CBNZ -> !op_zero; B -> 1. Flags are ignored for CBZ/CBNZ/B.
REQ-017 SHALL use cond table: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1.
REQ-018 SHALL hold take_branch at its previous value when eval_valid=0; consumers use it only with take_valid.
REQ-019 SHALL increment taken_count by 1 in the cycle take_valid & take_branch are registered high; saturate at all-ones, no wrap.
REQ-020 SHALL treat flag_we and eval_valid in the same cycle per REQ-030/031; flags_q updates regardless.

Reset
REQ-021 SHALL, on reset=1 at clk, set flags_q=4'b0000, take_valid=0, take_branch=0, taken_count=0.
REQ-022 SHALL give reset priority over flag_we and eval_valid; a request present in the reset cycle is dropped (take_valid=0 next cycle).
REQ-023 SHALL, after reset, evaluate BCOND against flags 0000 until the first flag_we (e.g. EQ not taken, NE taken).

Configuration
REQ-024 SHALL recognise macro COND_FLAG_BYPASS_EN.
REQ-030 SHALL, with COND_FLAG_BYPASS_EN defined, evaluate a same-cycle BCOND request against the incoming flags (flag_we=1) instead of flags_q.
REQ-031 SHALL, without COND_FLAG_BYPASS_EN, always evaluate against flags_q (pre-update value); the pipeline must insert one bubble.

Structure
REQ-025 SHALL place in shared package cond_pkg: cond_e enum (EQ..NV, 4-bit), br_mode_e enum (2-bit), flags_t packed struct {n,z,c,v}.
REQ-026 SHALL implement the cond table as a combinational sub-module cond_eval (inputs flags_t, cond_e; output 1-bit), instantiated once.
REQ-027 SHALL hold all registers in cond_flag_unit; cond_eval has no state.

Verification
REQ-028 SHALL cover: reset; eval BCOND EQ then NE with no flag_we -> take_branch 0 then 1, take_valid one cycle after each request.
REQ-029 SHALL cover: flag_we with N=1,V=0 then eval GE,LT,GT,LE -> 0,1,0,1; flag_we with Z=1,C=1 then HI,LS -> 0,1.
REQ-032 SHALL cover: same-cycle flag_we Z=1 (flags_q Z=0) and eval EQ -> take_branch 1 with COND_FLAG_BYPASS_EN, 0 without.
REQ-033 SHALL cover: CBZ op_zero=1 -> 1; CBNZ op_zero=1 -> 0; B with flags 0000 -> 1; flags_q unchanged throughout.
REQ-034 SHALL cover: CNT_W=3, 9 consecutive taken B requests -> taken_count 1..7 then holds 7; reset mid-stream -> taken_count 0, take_valid 0 next cycle.
